// File: rtl/multicycle_controller.sv
// Main control FSM for the multi-cycle CPU: sequences fetch/decode/execute/memory/writeback,
// waits on a memory ready handshake with a timeout, and counts retired instructions.
module multicycle_controller #(
   parameter logic [5:0] OP_RTYPE    = 6'h00,
   parameter logic [5:0] OP_ADDI     = 6'h08,
   parameter logic [5:0] OP_LW       = 6'h23,
   parameter logic [5:0] OP_SW       = 6'h2B,
   parameter logic [5:0] OP_BEQ      = 6'h04,
   parameter logic [5:0] OP_J        = 6'h02,
   parameter logic [5:0] OP_HALT     = 6'h3F,
   parameter int         MEM_TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [5:0]  op_in,
   input  logic        alu_zero,
   input  logic        mem_ready,
   output logic        ir_write,
   output logic        pc_write,
   output logic [1:0]  pc_src,
   output logic        mem_read,
   output logic        mem_write,
   output logic        iord,
   output logic        reg_write,
   output logic        mem_to_reg,
   output logic        alu_src_imm,
   output logic [1:0]  alu_op,
   output logic [2:0]  state,
   output logic        halted,
   output logic        fault,
   output logic [31:0] retired
);

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4,
      S_HALT   = 3'd5
   } state_t;

   localparam int WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

   state_t             state_q, state_d;
   logic [WAIT_W-1:0]  wait_q, wait_d;
   logic               fault_q, fault_d;
   logic [31:0]        retired_q, retired_d;
   logic               retire;
   logic               ir_write_raw, pc_write_raw, reg_write_raw, mem_write_raw;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= S_FETCH;
         wait_q    <= '0;
         fault_q   <= 1'b0;
         retired_q <= '0;
      end else begin
         state_q   <= state_d;
         wait_q    <= wait_d;
         fault_q   <= fault_d;
         retired_q <= retired_d;
      end
   end

   // Next state and control outputs; the wait counter only survives while a state repeats.
   always_comb begin
      state_d       = state_q;
      wait_d        = '0;
      fault_d       = fault_q;
      retire        = 1'b0;
      ir_write_raw  = 1'b0;
      pc_write_raw  = 1'b0;
      reg_write_raw = 1'b0;
      mem_write_raw = 1'b0;
      pc_src        = 2'd0;
      mem_read      = 1'b0;
      iord          = 1'b0;
      mem_to_reg    = 1'b0;
      alu_src_imm   = 1'b0;
      alu_op        = 2'd0;

      case (state_q)
         S_FETCH: begin
            mem_read = 1'b1;
            if (mem_ready) begin
               ir_write_raw = 1'b1;
               pc_write_raw = 1'b1;
               state_d      = S_DECODE;
            end else if (wait_q == WAIT_LAST) begin
               mem_read = 1'b0;
               fault_d  = 1'b1;
               state_d  = S_HALT;
            end else begin
               wait_d = wait_q + 1'b1;
            end
         end

         S_DECODE: begin
            alu_src_imm = 1'b1;
            case (op_in)
               OP_J: begin
                  pc_write_raw = 1'b1;
                  pc_src       = 2'd2;
                  retire       = 1'b1;
                  state_d      = S_FETCH;
               end
               OP_HALT: begin
                  retire  = 1'b1;
                  state_d = S_HALT;
               end
               OP_RTYPE, OP_ADDI, OP_LW, OP_SW, OP_BEQ: state_d = S_EXEC;
               default: begin
                  fault_d = 1'b1;
                  state_d = S_HALT;
               end
            endcase
         end

         S_EXEC: begin
            case (op_in)
               OP_RTYPE: begin
                  alu_op  = 2'd2;
                  state_d = S_WB;
               end
               OP_ADDI: begin
                  alu_src_imm = 1'b1;
                  state_d     = S_WB;
               end
               OP_LW, OP_SW: begin
                  alu_src_imm = 1'b1;
                  state_d     = S_MEM;
               end
               OP_BEQ: begin
                  alu_op = 2'd1;
                  if (alu_zero) begin
                     pc_write_raw = 1'b1;
                     pc_src       = 2'd1;
                  end
                  retire  = 1'b1;
                  state_d = S_FETCH;
               end
               default: begin
                  fault_d = 1'b1;
                  state_d = S_HALT;
               end
            endcase
         end

         // Request and address select stay constant until memory acknowledges or we time out.
         S_MEM: begin
            iord = 1'b1;
            if (op_in == OP_LW || op_in == OP_SW) begin
               mem_read      = (op_in == OP_LW);
               mem_write_raw = (op_in == OP_SW);
               if (mem_ready) begin
                  if (op_in == OP_LW) begin
                     state_d = S_WB;
                  end else begin
                     retire  = 1'b1;
                     state_d = S_FETCH;
                  end
               end else if (wait_q == WAIT_LAST) begin
                  mem_read      = 1'b0;
                  mem_write_raw = 1'b0;
                  fault_d       = 1'b1;
                  state_d       = S_HALT;
               end else begin
                  wait_d = wait_q + 1'b1;
               end
            end else begin
               fault_d = 1'b1;
               state_d = S_HALT;
            end
         end

         S_WB: begin
            reg_write_raw = 1'b1;
            mem_to_reg    = (op_in == OP_LW);
            retire        = 1'b1;
            state_d       = S_FETCH;
         end

         S_HALT: state_d = S_HALT;

         default: begin
            fault_d = 1'b1;
            state_d = S_HALT;
         end
      endcase

      retired_d = retired_q + 32'(retire);
   end

   // Write enables are suppressed while reset is held so an aborted instruction cannot commit.
   assign ir_write  = ir_write_raw  & ~reset;
   assign pc_write  = pc_write_raw  & ~reset;
   assign reg_write = reg_write_raw & ~reset;
   assign mem_write = mem_write_raw & ~reset;

   assign state   = state_q;
   assign halted  = (state_q == S_HALT);
   assign fault   = fault_q;
   assign retired = retired_q;

endmodule
